// File: rtl/turbo_pb_sched_if.sv
// Bundle between the PB scheduler, its descriptor/soft-bit sources, the
// length/enable block and the decoder bank handshake.
interface turbo_pb_sched_if;
  logic       desc_vld;
  logic [1:0] desc_size;
  logic       desc_rdy;
  logic       in_vld;
  logic       in_rdy;
  logic [1:0] tl_pb_size;
  logic       tl_din_vld;
  logic       tl_done;
  logic       bank_sel;
  logic [1:0] bank_full;
  logic [1:0] bank_release;
  logic       pb_busy;
  logic       pb_done;
  logic       err_size;
  logic       err_timeout;

  modport slave (
    input  desc_vld, desc_size, in_vld, tl_done, bank_release,
    output desc_rdy, in_rdy, tl_pb_size, tl_din_vld, bank_sel, bank_full,
           pb_busy, pb_done, err_size, err_timeout
  );

  modport master (
    output desc_vld, desc_size, in_vld, tl_done, bank_release,
    input  desc_rdy, in_rdy, tl_pb_size, tl_din_vld, bank_sel, bank_full,
           pb_busy, pb_done, err_size, err_timeout
  );
endinterface

// File: rtl/turbo_pb_sched.sv
// PB sequencer in front of the turbo length/enable block: descriptor FIFO,
// pb_size programming, soft-bit pair metering and interleaver bank ping-pong.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a descriptor and a free target bank
// LOAD      | pb_size held stable for SETTLE cycles before the first pair
// RUN       | soft-bit pairs accepted until len pairs have been handed over
// WAIT_DONE | waiting for tl_done, bounded by the TMO timer
module turbo_pb_sched #(
  parameter int LEN_PB16  = 64,
  parameter int LEN_PB136 = 544,
  parameter int LEN_PB520 = 2080,
  parameter int SETTLE    = 2,
  parameter int TMO       = 255
) (
  input  logic            clk,
  input  logic            n_rst,
  turbo_pb_sched_if.slave bus
);

  localparam logic [11:0] LEN0      = 12'(LEN_PB16);
  localparam logic [11:0] LEN1      = 12'(LEN_PB136);
  localparam logic [11:0] LEN2      = 12'(LEN_PB520);
  localparam logic [7:0]  SETTLE_TC = 8'(SETTLE - 1);
  localparam logic [7:0]  TMO_TC    = 8'(TMO);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT_DONE} state_t;

  state_t      state, state_nxt;

  logic [1:0]  fifo_mem [2];
  logic        fifo_wp, fifo_rp;
  logic [1:0]  fifo_cnt;
  logic [1:0]  head;
  logic        fifo_empty, desc_rdy_c, push, pop;

  logic [11:0] cnt, len;
  logic [7:0]  timer;
  logic [1:0]  pb_size_q;
  logic        bank_sel_q;
  logic [1:0]  bank_full_q, set_mask;

  logic        launch, in_rdy_c, hs, last_pair;
  logic        pb_done_c, err_size_c, err_timeout_c;

  function automatic logic [11:0] len_of(input logic [1:0] code);
    case (code)
      2'd0:    return LEN0;
      2'd1:    return LEN1;
      default: return LEN2;
    endcase
  endfunction

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign head       = fifo_mem[fifo_rp];
  assign desc_rdy_c = (fifo_cnt != 2'd2);
  assign push       = bus.desc_vld & desc_rdy_c;
  assign hs         = bus.in_vld & in_rdy_c;
  assign last_pair  = hs && (cnt == len - 12'd1);

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    launch        = 1'b0;
    in_rdy_c      = 1'b0;
    pb_done_c     = 1'b0;
    err_size_c    = 1'b0;
    err_timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          // illegal codes are dropped without looking at the bank
          if (head == 2'd3) begin
            pop        = 1'b1;
            err_size_c = 1'b1;
          end else if (!bank_full_q[bank_sel_q]) begin
            pop       = 1'b1;
            launch    = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (timer == SETTLE_TC) state_nxt = RUN;
      end
      RUN: begin
        in_rdy_c = (cnt < len);
        if (last_pair) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tl_done) begin
          pb_done_c = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TMO_TC) begin
          err_timeout_c = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= bus.desc_size;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign set_mask = pb_done_c ? (bank_sel_q ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt         <= 12'd0;
      len         <= 12'd0;
      timer       <= 8'd0;
      pb_size_q   <= 2'd0;
      bank_sel_q  <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      if (launch) begin
        pb_size_q <= head;
        len       <= len_of(head);
        cnt       <= 12'd0;
      end else if (hs) begin
        cnt <= cnt + 12'd1;
      end
      // one timer serves both the settle hold and the done watchdog
      if (state_nxt != state)
        timer <= 8'd0;
      else if (state == LOAD || state == WAIT_DONE)
        timer <= timer + 8'd1;
      bank_full_q <= (bank_full_q & ~bus.bank_release) | set_mask;
      if (pb_done_c) bank_sel_q <= ~bank_sel_q;
    end
  end

  assign bus.desc_rdy    = desc_rdy_c;
  assign bus.in_rdy      = in_rdy_c;
  assign bus.tl_pb_size  = pb_size_q;
  assign bus.tl_din_vld  = hs;
  assign bus.bank_sel    = bank_sel_q;
  assign bus.bank_full   = bank_full_q;
  assign bus.pb_busy     = (state != IDLE);
  assign bus.pb_done     = pb_done_c;
  assign bus.err_size    = err_size_c;
  assign bus.err_timeout = err_timeout_c;

endmodule

// File: tb/tb_turbo_pb_sched.sv
// Directed bench for turbo_pb_sched: single-PB flow, bank ping-pong and stall,
// illegal size codes, throttled input, done timeout and reset mid-PB.
module tb_turbo_pb_sched;
  localparam int SETTLE = 2;
  // {busy, bank_full, bank_sel, pb_size, desc_rdy, in_rdy, pb_done, err_size, err_timeout, din_vld}
  localparam logic [11:0] RST_VEC = 12'h020;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   hs;
  bit   seen3 = 1'b0;

  turbo_pb_sched_if bus();

  turbo_pb_sched dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.tl_pb_size === 2'd3) seen3 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [11:0] out_vec();
    return {bus.pb_busy, bus.bank_full, bus.bank_sel, bus.tl_pb_size, bus.desc_rdy,
            bus.in_rdy, bus.pb_done, bus.err_size, bus.err_timeout, bus.tl_din_vld};
  endfunction

  task automatic do_reset(input string tag);
    n_rst = 1'b0;
    bus.desc_vld = 1'b0; bus.desc_size = 2'd0; bus.in_vld = 1'b0;
    bus.tl_done = 1'b0;  bus.bank_release = 2'b00;
    tick(); tick();
    n_rst = 1'b1;
    #1;
    chk({tag, "_reset_outputs"}, 32'(out_vec()), 32'(RST_VEC));
  endtask

  task automatic push(input logic [1:0] code);
    bus.desc_vld = 1'b1; bus.desc_size = code;
    tick();
    bus.desc_vld = 1'b0;
  endtask

  task automatic start_pb(input logic [1:0] code, input string tag);
    int t = 0;
    int s = 0;
    #1;
    while (bus.pb_busy !== 1'b1 && t < 20) begin tick(); #1; t++; end
    chk({tag, "_launch"}, 32'(bus.pb_busy), 32'd1);
    chk({tag, "_pb_size"}, 32'(bus.tl_pb_size), 32'(code));
    while (bus.pb_busy === 1'b1 && bus.in_rdy !== 1'b1 && s < 10) begin tick(); #1; s++; end
    chk({tag, "_settle"}, 32'(s), 32'(SETTLE));
  endtask

  task automatic feed(input int max_hs, input bit toggle, input string tag, output int n);
    int t = 0;
    int bad = 0;
    n = 0;
    while (bus.in_rdy === 1'b1 && n < max_hs && t < 5000) begin
      bus.in_vld = toggle ? ~t[0] : 1'b1;
      #1;
      if (bus.tl_din_vld === 1'b1) n++;
      if (bus.tl_din_vld !== bus.in_vld) bad++;
      tick(); t++;
    end
    chk({tag, "_din_vld_follow"}, 32'(bad), 32'd0);
  endtask

  task automatic end_run(input int exp_len, input int n, input string tag);
    bus.in_vld = 1'b1;
    #1;
    chk({tag, "_pairs"}, 32'(n), 32'(exp_len));
    chk({tag, "_wait_state"}, 32'({bus.pb_busy, bus.in_rdy, bus.tl_din_vld}), 32'b100);
  endtask

  task automatic done_pb(input logic [1:0] rel, input string tag);
    repeat (3) tick();
    bus.tl_done = 1'b1; bus.bank_release = rel;
    #1;
    chk({tag, "_pb_done"}, 32'(bus.pb_done), 32'd1);
    tick();
    bus.tl_done = 1'b0; bus.bank_release = 2'b00;
    #1;
    chk({tag, "_idle"}, 32'({bus.pb_busy, bus.pb_done}), 32'b00);
  endtask

  initial begin
    int w;
    int busy_cnt;

    // 1: single 16-octet PB, in_vld held high
    do_reset("t1");
    bus.in_vld = 1'b1;
    push(2'd0);
    start_pb(2'd0, "t1");
    feed(4096, 1'b0, "t1", hs);
    end_run(64, hs, "t1");
    done_pb(2'b00, "t1");
    chk("t1_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b011);
    bus.bank_release = 2'b10;           // bank1 is not full: no effect
    tick();
    bus.bank_release = 2'b00;
    #1;
    chk("t1_release_nonfull", 32'(bus.bank_full), 32'b01);

    // 2: back-to-back codes 1 and 2, then stall with both banks held
    do_reset("t2");
    bus.in_vld = 1'b1;
    push(2'd1);
    push(2'd2);                          // pushed while code 1 is popped
    start_pb(2'd1, "t2a");
    chk("t2_rdy_after_pushpop", 32'(bus.desc_rdy), 32'd1);
    feed(4096, 1'b0, "t2a", hs);
    end_run(544, hs, "t2a");
    done_pb(2'b00, "t2a");
    chk("t2a_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b011);
    start_pb(2'd2, "t2b");
    feed(4096, 1'b0, "t2b", hs);
    end_run(2080, hs, "t2b");
    done_pb(2'b00, "t2b");
    chk("t2b_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b110);
    push(2'd0);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bus.tl_done = (i == 2);            // stray done while IDLE
      #1;
      if (bus.pb_busy !== 1'b0 || bus.pb_done !== 1'b0) busy_cnt++;
      tick();
    end
    bus.tl_done = 1'b0;
    #1;
    chk("t2_stall", 32'(busy_cnt), 32'd0);
    chk("t2_stall_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b110);
    chk("t2_stall_rdy", 32'(bus.desc_rdy), 32'd1);
    push(2'd0);
    #1;
    chk("t2_fifo_full", 32'(bus.desc_rdy), 32'd0);
    bus.bank_release = 2'b01;
    tick();
    bus.bank_release = 2'b00;
    #1;
    chk("t2_released", 32'(bus.bank_full), 32'b10);
    start_pb(2'd0, "t2c");
    feed(4096, 1'b0, "t2c", hs);
    end_run(64, hs, "t2c");
    done_pb(2'b10, "t2c");               // set bank0 and release bank1 together
    chk("t2c_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b011);
    start_pb(2'd0, "t2d");
    feed(4096, 1'b0, "t2d", hs);
    end_run(64, hs, "t2d");
    done_pb(2'b00, "t2d");
    chk("t2d_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b110);

    // 3: illegal code between two legal ones
    do_reset("t3");
    bus.in_vld = 1'b1;
    push(2'd0);
    start_pb(2'd0, "t3a");
    feed(4096, 1'b0, "t3a", hs);
    end_run(64, hs, "t3a");
    push(2'd3);
    push(2'd0);
    done_pb(2'b00, "t3a");
    chk("t3_err_size", 32'({bus.err_size, bus.pb_busy}), 32'b10);
    tick();
    #1;
    chk("t3_err_single", 32'(bus.err_size), 32'd0);
    start_pb(2'd0, "t3b");
    feed(4096, 1'b0, "t3b", hs);
    end_run(64, hs, "t3b");
    done_pb(2'b00, "t3b");
    chk("t3_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b110);
    chk("t3_no_size3", 32'(seen3), 32'd0);

    // 4: throttled input on a 136-octet PB
    do_reset("t4");
    push(2'd1);
    start_pb(2'd1, "t4");
    feed(4096, 1'b1, "t4", hs);
    end_run(544, hs, "t4");
    done_pb(2'b00, "t4");

    // 5: done withheld -> timeout, bank untouched, same bank reused
    do_reset("t5");
    bus.in_vld = 1'b1;
    push(2'd0);
    start_pb(2'd0, "t5a");
    feed(4096, 1'b0, "t5a", hs);
    end_run(64, hs, "t5a");
    w = 0;
    while (bus.err_timeout !== 1'b1 && w < 400) begin tick(); #1; w++; end
    chk("t5_timeout_cycle", 32'(w), 32'd255);
    chk("t5_no_done", 32'(bus.pb_done), 32'd0);
    tick();
    #1;
    chk("t5_after_timeout", 32'({bus.pb_busy, bus.err_timeout, bus.bank_full, bus.bank_sel}), 32'b00000);
    push(2'd0);
    start_pb(2'd0, "t5b");
    feed(4096, 1'b0, "t5b", hs);
    end_run(64, hs, "t5b");
    done_pb(2'b00, "t5b");
    chk("t5b_banks", 32'({bus.bank_full, bus.bank_sel}), 32'b011);

    // 6: reset in the middle of a 136-octet PB with a second desc queued
    do_reset("t6");
    bus.in_vld = 1'b1;
    push(2'd1);
    start_pb(2'd1, "t6");
    feed(300, 1'b0, "t6", hs);
    chk("t6_mid_run", 32'({bus.in_rdy, 12'(hs)}), 32'({1'b1, 12'd300}));
    push(2'd2);
    n_rst = 1'b0;
    tick();
    #1;
    chk("t6_reset_outputs", 32'(out_vec()), 32'(RST_VEC));
    n_rst = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      if (bus.pb_busy !== 1'b0 || bus.pb_done !== 1'b0) busy_cnt++;
    end
    chk("t6_fifo_empty", 32'(busy_cnt), 32'd0);
    chk("t6_final", 32'(out_vec()), 32'(RST_VEC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
